// File: rtl/quire_acc_pkg.sv
// Shared configuration helpers for the quire datapath. The derived widths are
// computed from (N, ES, IS_PROD, LOG_NB_ACCUM) so the accumulator and the
// quire-to-posit rounder always agree on the quire geometry.
package quire_acc_pkg;

  // Sanity check of a configuration; derived sizes collapse to 0 when invalid
  function automatic bit cfg_ok(input int n, input int es, input int is_prod, input int log_nb);
    return (n >= 4) && (es >= 0) && ((is_prod == 0) || (is_prod == 1)) && (log_nb >= 0);
  endfunction

  // Fraction bits of a single decoded posit
  function automatic int fw(input int n, input int es, input int is_prod, input int log_nb);
    return cfg_ok(n, es, is_prod, log_nb) ? (n - 3 - es) : 0;
  endfunction

  // Fraction bits presented to the accumulator (products carry 2*FW+1)
  function automatic int frac_w(input int n, input int es, input int is_prod, input int log_nb);
    return (is_prod != 0) ? (2 * fw(n, es, is_prod, log_nb) + 1) : fw(n, es, is_prod, log_nb);
  endfunction

  // Largest magnitude of the scale
  function automatic int max_scale(input int n, input int es, input int is_prod, input int log_nb);
    return cfg_ok(n, es, is_prod, log_nb) ? (((is_prod != 0) ? 2 : 1) * (n - 2) * (2 ** es)) : 0;
  endfunction

  // Width of the signed scale field
  function automatic int scale_w(input int n, input int es, input int is_prod, input int log_nb);
    return $clog2(max_scale(n, es, is_prod, log_nb) + 1) + 1;
  endfunction

  // Minimum quire size covering every product exactly
  function automatic int nqmin(input int n, input int es, input int is_prod, input int log_nb);
    return cfg_ok(n, es, is_prod, log_nb) ? ((2 ** (es + 2)) * (n - 2) + 1) : 0;
  endfunction

  // Full quire width including carry-guard bits
  function automatic int quire_size(input int n, input int es, input int is_prod, input int log_nb);
    return nqmin(n, es, is_prod, log_nb) + log_nb;
  endfunction

  // Quire bit position of 2^0
  function automatic int bpp(input int n, input int es, input int is_prod, input int log_nb);
    return (nqmin(n, es, is_prod, log_nb) - 1) / 2;
  endfunction

endpackage

// File: rtl/quire_acc_align.sv
// Combinational aligner: places {1,fraction} so that the hidden bit lands at
// quire bit BPP+scale. Bits falling below bit 0 are truncated and reported as
// inexact; a hidden bit at or above the quire sign bit is a magnitude overflow.
module quire_align
  import quire_acc_pkg::*;
#(
  parameter int  POSIT_WIDTH  = 8,
  parameter int  ES           = 1,
  parameter int  IS_PROD      = 1,
  parameter int  LOG_NB_ACCUM = 10,
  localparam int FRAC_W       = frac_w(POSIT_WIDTH, ES, IS_PROD, LOG_NB_ACCUM),
  localparam int SCALE_W      = scale_w(POSIT_WIDTH, ES, IS_PROD, LOG_NB_ACCUM),
  localparam int QUIRE_SIZE   = quire_size(POSIT_WIDTH, ES, IS_PROD, LOG_NB_ACCUM),
  localparam int BPP          = bpp(POSIT_WIDTH, ES, IS_PROD, LOG_NB_ACCUM)
) (
  input  logic [FRAC_W-1:0]         fraction,
  input  logic signed [SCALE_W-1:0] scale,
  output logic [QUIRE_SIZE-1:0]     mag,
  output logic                      inexact,
  output logic                      mag_ovf
);

  logic [FRAC_W:0] ext_s;
  logic [FRAC_W:0] ones_s;
  int              hid_pos_s;
  int              shift_s;
  int              rsh_s;

  // Shift the significand into quire position and flag lost or oversized bits
  always_comb begin
    ext_s     = {1'b1, fraction};
    ones_s    = '1;
    hid_pos_s = BPP + int'(scale);
    shift_s   = hid_pos_s - FRAC_W;
    rsh_s     = 0;
    mag       = '0;
    inexact   = 1'b0;
    if (shift_s >= 0) begin
      mag     = QUIRE_SIZE'(ext_s) << shift_s;
      inexact = 1'b0;
    end else begin
      rsh_s   = -shift_s;
      mag     = QUIRE_SIZE'(ext_s) >> rsh_s;
      inexact = |(ext_s & ~(ones_s << rsh_s));
    end
    mag_ovf = (hid_pos_s >= (QUIRE_SIZE - 1));
  end

endmodule

// File: rtl/quire_acc.sv
// Windowed exact quire accumulator: skid-buffered input handshake, an align
// stage, and an accumulate stage that also owns the output registers and the
// sticky NaR / overflow / inexact window flags.
module quire_acc
  import quire_acc_pkg::*;
#(
  parameter int  POSIT_WIDTH   = 8,
  parameter int  ES            = 1,
  parameter int  LOG_NB_ACCUM  = 10,
  parameter int  IS_PROD       = 1,
  parameter int  OUTPUT_ON_EOW = 1,
  localparam int FRAC_W        = frac_w(POSIT_WIDTH, ES, IS_PROD, LOG_NB_ACCUM),
  localparam int SCALE_W       = scale_w(POSIT_WIDTH, ES, IS_PROD, LOG_NB_ACCUM),
  localparam int QS            = quire_size(POSIT_WIDTH, ES, IS_PROD, LOG_NB_ACCUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rts_i,
  output logic                      rtr_o,
  input  logic                      sow_i,
  input  logic                      eow_i,
  input  logic [FRAC_W-1:0]         fraction_i,
  input  logic signed [SCALE_W-1:0] scale_i,
  input  logic                      sign_i,
  input  logic                      zero_i,
  input  logic                      NaR_i,
  input  logic                      rtr_i,
  output logic                      rts_o,
  output logic                      sow_o,
  output logic                      eow_o,
  output logic [QS-1:0]             data_o,
  output logic                      sign_o,
  output logic                      zero_o,
  output logic                      NaR_o,
  output logic                      overflow_o,
  output logic                      inexact_o
);

  logic process_en_s, xfer_s, rtr_r, rts_r;
  // skid entry
  logic skid_v_r, skid_sow_r, skid_eow_r, skid_sign_r, skid_zero_r, skid_nar_r;
  logic [FRAC_W-1:0]         skid_frac_r;
  logic signed [SCALE_W-1:0] skid_scale_r;
  // beat entering the align stage
  logic in_v_s, in_sow_s, in_eow_s, in_sign_s, in_zero_s, in_nar_s;
  logic [FRAC_W-1:0]         in_frac_s;
  logic signed [SCALE_W-1:0] in_scale_s;
  logic [QS-1:0] mag_s;
  logic          inx_s, mag_ovf_s;
  // align stage
  logic s1_v_r, s1_sow_r, s1_eow_r, s1_sign_r, s1_skip_r, s1_nar_r, s1_inx_r, s1_ovf_r;
  logic [QS-1:0] s1_mag_r;
  // accumulate stage
  logic [QS-1:0] quire_r, base_s, term_s, quire_n_s;
  logic [QS:0]   sum_ext_s;
  logic add_ovf_s, nar_n_s, ovf_n_s, inx_n_s;
  logic sow_r, eow_r, sign_r, zero_r, nar_r, ovf_r, inx_r;

  assign process_en_s = rtr_i | ~rts_r;
  assign xfer_s       = rts_i & rtr_r;

  // Ready toward upstream is process_en delayed by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rtr_r <= 1'b0;
    else        rtr_r <= process_en_s;
  end

  // Skid entry catches the one beat accepted after the pipeline stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v_r <= 1'b0; skid_sow_r <= 1'b0; skid_eow_r <= 1'b0; skid_sign_r <= 1'b0;
      skid_zero_r <= 1'b0; skid_nar_r <= 1'b0; skid_frac_r <= '0; skid_scale_r <= '0;
    end else if (xfer_s && !process_en_s) begin
      skid_v_r <= 1'b1; skid_sow_r <= sow_i; skid_eow_r <= eow_i; skid_sign_r <= sign_i;
      skid_zero_r <= zero_i; skid_nar_r <= NaR_i; skid_frac_r <= fraction_i; skid_scale_r <= scale_i;
    end else if (process_en_s) begin
      skid_v_r <= 1'b0;
    end
  end

  // Pending skid beat takes precedence over the live input
  always_comb begin
    in_v_s = 1'b0; in_sow_s = 1'b0; in_eow_s = 1'b0; in_sign_s = 1'b0;
    in_zero_s = 1'b0; in_nar_s = 1'b0; in_frac_s = '0; in_scale_s = '0;
    if (skid_v_r) begin
      in_v_s = 1'b1; in_sow_s = skid_sow_r; in_eow_s = skid_eow_r; in_sign_s = skid_sign_r;
      in_zero_s = skid_zero_r; in_nar_s = skid_nar_r; in_frac_s = skid_frac_r; in_scale_s = skid_scale_r;
    end else begin
      in_v_s = xfer_s; in_sow_s = sow_i; in_eow_s = eow_i; in_sign_s = sign_i;
      in_zero_s = zero_i; in_nar_s = NaR_i; in_frac_s = fraction_i; in_scale_s = scale_i;
    end
  end

  quire_align #(
    .POSIT_WIDTH (POSIT_WIDTH),
    .ES          (ES),
    .IS_PROD     (IS_PROD),
    .LOG_NB_ACCUM(LOG_NB_ACCUM)
  ) u_align (
    .fraction(in_frac_s),
    .scale   (in_scale_s),
    .mag     (mag_s),
    .inexact (inx_s),
    .mag_ovf (mag_ovf_s)
  );

  // Align stage register; zero and NaR beats carry no rounding or overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r <= 1'b0; s1_sow_r <= 1'b0; s1_eow_r <= 1'b0; s1_sign_r <= 1'b0; s1_skip_r <= 1'b0;
      s1_nar_r <= 1'b0; s1_inx_r <= 1'b0; s1_ovf_r <= 1'b0; s1_mag_r <= '0;
    end else if (process_en_s) begin
      s1_v_r    <= in_v_s;
      s1_sow_r  <= in_sow_s;
      s1_eow_r  <= in_eow_s;
      s1_sign_r <= in_sign_s;
      s1_skip_r <= in_zero_s | in_nar_s;
      s1_nar_r  <= in_nar_s;
      s1_inx_r  <= inx_s & ~(in_zero_s | in_nar_s);
      s1_ovf_r  <= mag_ovf_s & ~(in_zero_s | in_nar_s);
      s1_mag_r  <= mag_s;
    end
  end

  // Next quire value and sticky flags; sow restarts from zero and clean flags
  always_comb begin
    base_s    = s1_sow_r ? '0 : quire_r;
    term_s    = s1_sign_r ? -s1_mag_r : s1_mag_r;
    sum_ext_s = {base_s[QS-1], base_s} + {term_s[QS-1], term_s};
    quire_n_s = base_s;
    add_ovf_s = 1'b0;
    if (s1_skip_r) begin
      quire_n_s = base_s;
      add_ovf_s = 1'b0;
    end else begin
      quire_n_s = sum_ext_s[QS-1:0];
      add_ovf_s = sum_ext_s[QS] ^ sum_ext_s[QS-1];
    end
    nar_n_s = (s1_sow_r ? 1'b0 : nar_r) | s1_nar_r;
    ovf_n_s = (s1_sow_r ? 1'b0 : ovf_r) | s1_ovf_r | add_ovf_s;
    inx_n_s = (s1_sow_r ? 1'b0 : inx_r) | s1_inx_r;
  end

  // Accumulate stage and output registers; everything holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_r <= 1'b0; sow_r <= 1'b0; eow_r <= 1'b0; quire_r <= '0; sign_r <= 1'b0;
      zero_r <= 1'b1; nar_r <= 1'b0; ovf_r <= 1'b0; inx_r <= 1'b0;
    end else if (process_en_s) begin
      rts_r <= s1_v_r & (s1_eow_r | (OUTPUT_ON_EOW == 0));
      if (s1_v_r) begin
        sow_r   <= s1_sow_r;
        eow_r   <= s1_eow_r;
        quire_r <= quire_n_s;
        sign_r  <= quire_n_s[QS-1];
        zero_r  <= (quire_n_s == '0);
        nar_r   <= nar_n_s;
        ovf_r   <= ovf_n_s;
        inx_r   <= inx_n_s;
      end
    end
  end

  assign rtr_o      = rtr_r;
  assign rts_o      = rts_r;
  assign sow_o      = sow_r;
  assign eow_o      = eow_r;
  assign data_o     = quire_r;
  assign sign_o     = sign_r;
  assign zero_o     = zero_r;
  assign NaR_o      = nar_r;
  assign overflow_o = ovf_r;
  assign inexact_o  = inx_r;

endmodule
